// File: rtl/fsx_bg_line_renderer.sv
// Background line renderer: walks one tile row per line_start through VRAM8/VRAM32
// into a ping-pong line buffer; the pixel stage reads the opposite bank.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   line_start/line_y      render request pulse and screen line
//   scroll_x               [8:3] coarse tiles, [2:0] fine pixels
//   busy, line_done        render in progress / write bank complete pulse
//   vram8_addr/vram8_q     name + attribute fetch (1-cycle read latency)
//   vram32_addr/vram32_q   pattern + palette fetch (1-cycle read latency)
//   pix_x/pix_color        display pixel index and registered RRRGGGBB colour
module fsx_bg_line_renderer #(
  parameter int unsigned TILES_H   = 58,
  parameter logic [11:0] NT_BASE   = 12'h000,
  parameter logic [11:0] ATTR_BASE = 12'h7F8,
  parameter logic [11:0] PAT_BASE  = 12'h000,
  parameter logic [11:0] PAL_BASE  = 12'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [8:0]  scroll_x,
  output logic        busy,
  output logic        line_done,
  output logic [11:0] vram8_addr,
  input  logic [7:0]  vram8_q,
  output logic [11:0] vram32_addr,
  input  logic [31:0] vram32_q,
  input  logic [9:0]  pix_x,
  output logic [7:0]  pix_color
);

  // One extra tile is rendered so fine scroll can shift up to 7 pixels.
  localparam int unsigned NTILE = TILES_H + 1;
  localparam int unsigned DEPTH = NTILE * 8;
  localparam int unsigned TW    = $clog2(NTILE);
  localparam int unsigned AW    = TW + 3;
  localparam int unsigned VIS   = TILES_H * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NAME,
    S_ATTR,
    S_PAT,
    S_PAL,
    S_WRITE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            wr_bank_q;
  logic [2:0]      disp_fine_q;
  logic [2:0]      rend_fine_q;
  logic [11:0]     rowbase_q;
  logic [2:0]      vrow_q;
  logic [TW-1:0]   t_q;
  logic [TW-1:0]   col_q;
  logic [7:0]      tile_q;
  logic [3:0]      pal_q;
  logic [15:0]     hw_q;
  logic [7:0]      pix_color_q;

  logic [7:0]      buf_q [2][DEPTH];
  logic [7:0]      wr_pix [8];
  logic [AW-1:0]   wr_base;
  logic [AW-1:0]   rd_idx;
  logic            pix_vis;
  logic            last_tile;

  assign last_tile = (32'(t_q) >= TILES_H);
  assign wr_base   = {t_q, 3'b000};
  assign rd_idx    = AW'(32'(pix_x) + 32'(disp_fine_q));
  assign pix_vis   = (32'(pix_x) < VIS);
  assign pix_color = pix_color_q;

  // Next state and fetch addresses; line_start overrides everything,
  // including the DONE pulse.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    line_done   = 1'b0;
    vram8_addr  = 12'h000;
    vram32_addr = 12'h000;
    unique case (state_q)
      S_IDLE: begin
      end
      S_NAME: begin
        busy       = 1'b1;
        vram8_addr = NT_BASE + rowbase_q + 12'(col_q);
        state_d    = S_ATTR;
      end
      S_ATTR: begin
        busy       = 1'b1;
        vram8_addr = ATTR_BASE + rowbase_q + 12'(col_q);
        state_d    = S_PAT;
      end
      S_PAT: begin
        busy        = 1'b1;
        vram32_addr = PAT_BASE + {2'b00, tile_q, 2'b00}
                    + {10'd0, vrow_q[2:1]};
        state_d     = S_PAL;
      end
      S_PAL: begin
        busy        = 1'b1;
        vram32_addr = PAL_BASE + {8'd0, pal_q};
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        state_d = last_tile ? S_DONE : S_NAME;
      end
      S_DONE: begin
        line_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (line_start) begin
      state_d   = S_NAME;
      line_done = 1'b0;
    end
  end

  // Palette byte per pixel: 2-bit index picks a byte, index 0 = MSB.
  always_comb begin
    for (int p = 0; p < 8; p++) begin
      wr_pix[p] = 8'h00;
      unique case (hw_q[15-2*p -: 2])
        2'd0: wr_pix[p] = vram32_q[31:24];
        2'd1: wr_pix[p] = vram32_q[23:16];
        2'd2: wr_pix[p] = vram32_q[15:8];
        2'd3: wr_pix[p] = vram32_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= 1'b0;
      disp_fine_q <= 3'd0;
      rend_fine_q <= 3'd0;
      rowbase_q   <= 12'h000;
      vrow_q      <= 3'd0;
      t_q         <= '0;
      col_q       <= '0;
      tile_q      <= 8'h00;
      pal_q       <= 4'h0;
      hw_q        <= 16'h0000;
      pix_color_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      pix_color_q <= pix_vis ? buf_q[~wr_bank_q][rd_idx] : 8'h00;
      if (line_start) begin
        wr_bank_q   <= ~wr_bank_q;
        disp_fine_q <= rend_fine_q;
        rend_fine_q <= scroll_x[2:0];
        rowbase_q   <= 12'(32'(line_y[8:3]) * TILES_H);
        vrow_q      <= line_y[2:0];
        t_q         <= '0;
        col_q       <= TW'(32'(scroll_x[8:3]) % TILES_H);
      end else begin
        if (state_q == S_ATTR) tile_q <= vram8_q;
        if (state_q == S_PAT)  pal_q  <= vram8_q[3:0];
        if (state_q == S_PAL) begin
          hw_q <= vrow_q[0] ? vram32_q[15:0] : vram32_q[31:16];
        end
        if (state_q == S_WRITE && !last_tile) begin
          t_q   <= t_q + TW'(1);
          col_q <= (32'(col_q) == TILES_H - 1) ? '0 : col_q + TW'(1);
        end
      end
    end
  end

  // Line buffer is not reset; a whole tile lands in one cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) begin
      for (int p = 0; p < 8; p++) begin
        buf_q[wr_bank_q][wr_base + AW'(p)] <= wr_pix[p];
      end
    end
  end

endmodule

// File: tb/tb_fsx_bg_line_renderer.sv
// Directed bench for fsx_bg_line_renderer with TILES_H=4:
// fetch addresses, render latency, scroll, bank swap, abort and reset.
module tb_fsx_bg_line_renderer;

  localparam int TH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [8:0]  line_y;
  logic [8:0]  scroll_x;
  logic        busy;
  logic        line_done;
  logic [11:0] vram8_addr;
  logic [7:0]  vram8_q;
  logic [11:0] vram32_addr;
  logic [31:0] vram32_q;
  logic [9:0]  pix_x;
  logic [7:0]  pix_color;

  logic [7:0]  vram8  [4096];
  logic [31:0] vram32 [4096];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic seen;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram8_q  <= vram8[vram8_addr];
    vram32_q <= vram32[vram32_addr];
  end

  fsx_bg_line_renderer #(
    .TILES_H(TH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_y     (line_y),
    .scroll_x   (scroll_x),
    .busy       (busy),
    .line_done  (line_done),
    .vram8_addr (vram8_addr),
    .vram8_q    (vram8_q),
    .vram32_addr(vram32_addr),
    .vram32_q   (vram32_q),
    .pix_x      (pix_x),
    .pix_color  (pix_color)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input logic [8:0] y, input logic [8:0] sx);
    line_y     = y;
    scroll_x   = sx;
    line_start = 1'b1;
    cyc        = 0;
    step();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (line_done !== 1'b1 && cyc < 200) step();
    chk(tag, cyc, 26);
  endtask

  task automatic pix(input string tag, input logic [9:0] x,
                     input logic [7:0] e);
    pix_x = x;
    step();
    chk(tag, 32'(pix_color), 32'(e));
  endtask

  logic [7:0]  exp_a [8];
  logic [11:0] exp_nt [5];

  initial begin
    exp_a  = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    exp_nt = '{12'd5, 12'd6, 12'd7, 12'd4, 12'd5};
    for (int i = 0; i < 4096; i++) begin
      vram8[i]  = 8'h00;
      vram32[i] = 32'hFFFF_FFFF;
    end
    for (int c = 0; c < 4; c++) begin
      vram8[4 + c]         = 8'(c + 1);
      vram8[12'h7FC + c]   = 8'(c);
      vram32[4 * (c + 1)]  = 32'h1B1B_E4E4;
    end
    vram32[12'h400] = 32'hAABB_CCDD;
    vram32[12'h401] = 32'h1122_3344;
    vram32[12'h402] = 32'h5566_7788;
    vram32[12'h403] = 32'h99AB_CDEF;

    reset      = 1'b1;
    line_start = 1'b0;
    line_y     = 9'd0;
    scroll_x   = 9'd0;
    pix_x      = 10'd0;
    repeat (3) step();
    chk("rst pix", 32'(pix_color), 0);
    chk("rst busy", 32'(busy), 0);
    reset = 1'b0;
    pix_x = 10'd32;
    repeat (10) step();
    chk("idle busy", 32'(busy), 0);
    chk("idle done", 32'(line_done), 0);
    chk("idle a8", 32'(vram8_addr), 0);
    chk("idle a32", 32'(vram32_addr), 0);
    chk("idle pix", 32'(pix_color), 0);

    // line 9, no scroll: row 1, vrow 1
    start_line(9'd9, 9'd0);
    chk("t1 busy", 32'(busy), 1);
    chk("t1 name", 32'(vram8_addr), 32'h004);
    step();
    chk("t1 attr", 32'(vram8_addr), 32'h7FC);
    step();
    chk("t1 pat", 32'(vram32_addr), 32'h004);
    step();
    chk("t1 pal", 32'(vram32_addr), 32'h400);
    wait_done("t1 latency");
    step();
    chk("t1 done pulse", 32'(line_done), 0);
    chk("t1 idle busy", 32'(busy), 0);

    start_line(9'd9, 9'd0);
    for (int i = 0; i < 8; i++) pix("t1 pix", 10'(i), exp_a[i]);
    pix("t1 pix8", 10'd8, 8'h44);
    pix_x = 10'd11;
    #1;
    chk("pix hold", 32'(pix_color), 32'h44);
    step();
    chk("pix11", 32'(pix_color), 32'h11);
    pix("t1 pix31", 10'd31, 8'h99);
    pix("pix edge", 10'd32, 8'h00);
    wait_done("t2 latency");

    // coarse 1, fine 1
    start_line(9'd9, 9'd9);
    chk("sc name0", 32'(vram8_addr), 32'(exp_nt[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (5) step();
      chk("sc name", 32'(vram8_addr), 32'(exp_nt[i]));
    end
    wait_done("sc latency");
    start_line(9'd9, 9'd9);
    pix("sc pix0", 10'd0, 8'h33);
    pix("sc pix7", 10'd7, 8'h88);
    pix("sc pix30", 10'd30, 8'hAA);
    pix("sc pix31", 10'd31, 8'h44);
    wait_done("sc2 latency");

    // abandon a render 12 cycles in
    start_line(9'd9, 9'd0);
    seen = 1'b0;
    repeat (11) begin
      step();
      seen |= line_done;
    end
    line_start = 1'b1;
    cyc        = 0;
    step();
    line_start = 1'b0;
    chk("abort no done", 32'(seen), 0);
    wait_done("reissue latency");
    start_line(9'd9, 9'd0);
    pix("bank pix0", 10'd0, 8'hDD);
    pix("bank pix13", 10'd13, 8'h33);
    while (cyc < 26) step();
    chk("done seen", 32'(line_done), 1);
    line_start = 1'b1;
    #1;
    chk("done suppressed", 32'(line_done), 0);
    cyc = 0;
    step();
    line_start = 1'b0;
    chk("prio busy", 32'(busy), 1);
    wait_done("prio latency");

    // reset mid-render
    start_line(9'd9, 9'd0);
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst busy", 32'(busy), 0);
    chk("mrst a8", 32'(vram8_addr), 0);
    chk("mrst a32", 32'(vram32_addr), 0);
    chk("mrst done", 32'(line_done), 0);
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= line_done;
    end
    chk("mrst no done", 32'(seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
